// File: rtl/cache_refill_ctrl_if.sv
// rtl/cache_refill_ctrl_if.sv - Miss, memory-bus, fill and LRU signal bundle for cache_refill_ctrl
interface cache_refill_ctrl_if #(
    parameter int INDEX_W    = 8,
    parameter int LINE_WORDS = 4,
    parameter int TAG_W      = 32 - INDEX_W - $clog2(LINE_WORDS) - 2
);
    logic                        miss_req;
    logic [31:0]                 miss_addr;
    logic                        miss_ack;
    logic                        way_sel;
    logic [1:0]                  vic_valid;
    logic [1:0]                  vic_dirty;
    logic [2*TAG_W-1:0]          vic_tag;
    logic [2*LINE_WORDS*32-1:0]  vic_line;
    logic                        wr_req;
    logic [31:0]                 wr_addr;
    logic [LINE_WORDS*32-1:0]    wr_data;
    logic                        wr_rdy;
    logic                        rd_req;
    logic [31:0]                 rd_addr;
    logic                        rd_rdy;
    logic                        ret_valid;
    logic                        ret_last;
    logic [31:0]                 ret_data;
    logic [1:0]                  fill_we;
    logic [INDEX_W-1:0]          fill_index;
    logic [TAG_W-1:0]            fill_tag;
    logic [LINE_WORDS*32-1:0]    fill_line;
    logic                        way_sel_update;
    logic [1:0]                  hit;
    logic [INDEX_W-1:0]          lru_addr;

    // Controller side
    modport master (
        input  miss_req, miss_addr, way_sel, vic_valid, vic_dirty, vic_tag, vic_line,
               wr_rdy, rd_rdy, ret_valid, ret_last, ret_data,
        output miss_ack, wr_req, wr_addr, wr_data, rd_req, rd_addr,
               fill_we, fill_index, fill_tag, fill_line, way_sel_update, hit, lru_addr
    );

    // Pipeline / memory / RAM / LRU side
    modport slave (
        output miss_req, miss_addr, way_sel, vic_valid, vic_dirty, vic_tag, vic_line,
               wr_rdy, rd_rdy, ret_valid, ret_last, ret_data,
        input  miss_ack, wr_req, wr_addr, wr_data, rd_req, rd_addr,
               fill_we, fill_index, fill_tag, fill_line, way_sel_update, hit, lru_addr
    );
endinterface

// File: rtl/cache_refill_ctrl.sv
// rtl/cache_refill_ctrl.sv - 2-way cache miss refill controller; CACHE_WRITEBACK_EN adds dirty-victim write-back
module cache_refill_ctrl #(
    parameter int INDEX_W    = 8,
    parameter int LINE_WORDS = 4,
    parameter int TAG_W      = 32 - INDEX_W - $clog2(LINE_WORDS) - 2
) (
    input  logic                clk,
    input  logic                rst,
    cache_refill_ctrl_if.master bus
);
    localparam int OFF_W  = $clog2(LINE_WORDS) + 2;
    localparam int CNT_W  = $clog2(LINE_WORDS);
    localparam int LINE_W = LINE_WORDS * 32;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WB     = 3'd1;
    localparam logic [2:0] S_RD     = 3'd2;
    localparam logic [2:0] S_REFILL = 3'd3;
    localparam logic [2:0] S_UPDATE = 3'd4;
    localparam logic [2:0] S_ACK    = 3'd5;

    logic [2:0]         r_state;
    logic [INDEX_W-1:0] r_index;
    logic [TAG_W-1:0]   r_tag;
    logic               r_way;
    logic [CNT_W-1:0]   r_cnt;
    logic [LINE_W-1:0]  r_buf;

    logic [INDEX_W-1:0] w_miss_index;
    logic [TAG_W-1:0]   w_miss_tag;
    logic               w_go_wb;
    logic [1:0]         w_way_onehot;

    assign w_miss_index = bus.miss_addr[OFF_W +: INDEX_W];
    assign w_miss_tag   = bus.miss_addr[31 -: TAG_W];
    assign w_way_onehot = r_way ? 2'b10 : 2'b01;

`ifdef CACHE_WRITEBACK_EN
    logic [TAG_W-1:0]  r_vic_tag;
    logic [LINE_W-1:0] r_vic_line;
    logic              w_unused;

    assign w_go_wb  = bus.vic_valid[bus.way_sel] & bus.vic_dirty[bus.way_sel];
    assign w_unused = ^bus.miss_addr[OFF_W-1:0];

    // Snapshot the chosen victim's tag and data when the miss is accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vic_tag  <= '0;
            r_vic_line <= '0;
        end else if (r_state == S_IDLE && bus.miss_req) begin
            r_vic_tag  <= bus.way_sel ? bus.vic_tag[2*TAG_W-1:TAG_W] : bus.vic_tag[TAG_W-1:0];
            r_vic_line <= bus.way_sel ? bus.vic_line[2*LINE_W-1:LINE_W] : bus.vic_line[LINE_W-1:0];
        end
    end

    assign bus.wr_req  = (r_state == S_WB);
    assign bus.wr_addr = (r_state == S_WB) ? {r_vic_tag, r_index, {OFF_W{1'b0}}} : 32'd0;
    assign bus.wr_data = (r_state == S_WB) ? r_vic_line : '0;
`else
    logic w_unused;

    // Write-through: a victim never needs writing back, so its metadata is irrelevant
    assign w_go_wb  = 1'b0;
    assign w_unused = ^{bus.vic_valid, bus.vic_dirty, bus.vic_tag, bus.vic_line,
                        bus.wr_rdy, bus.miss_addr[OFF_W-1:0]};

    assign bus.wr_req  = 1'b0;
    assign bus.wr_addr = 32'd0;
    assign bus.wr_data = '0;
`endif

    // Miss sequencing: accept, optional write-back, read request, beat collection, fill, acknowledge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_index <= '0;
            r_tag   <= '0;
            r_way   <= 1'b0;
            r_cnt   <= '0;
            r_buf   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.miss_req) begin
                        r_index <= w_miss_index;
                        r_tag   <= w_miss_tag;
                        r_way   <= bus.way_sel;
                        r_state <= w_go_wb ? S_WB : S_RD;
                    end
                end
`ifdef CACHE_WRITEBACK_EN
                S_WB: begin
                    if (bus.wr_rdy) begin
                        r_state <= S_RD;
                    end
                end
`endif
                S_RD: begin
                    r_cnt <= '0;
                    if (bus.rd_rdy) begin
                        r_state <= S_REFILL;
                    end
                end
                S_REFILL: begin
                    // ret_last decides completion; the counter simply wraps
                    if (bus.ret_valid) begin
                        r_buf[32*int'(r_cnt) +: 32] <= bus.ret_data;
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (bus.ret_last) begin
                            r_state <= S_UPDATE;
                        end
                    end
                end
                S_UPDATE: r_state <= S_ACK;
                S_ACK:    r_state <= S_IDLE;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    // Memory read request for the missing line
    assign bus.rd_req  = (r_state == S_RD);
    assign bus.rd_addr = (r_state == S_RD) ? {r_tag, r_index, {OFF_W{1'b0}}} : 32'd0;

    // Tag/data RAM fill and LRU most-recently-used update, both confined to UPDATE
    assign bus.fill_we        = (r_state == S_UPDATE) ? w_way_onehot : 2'b00;
    assign bus.fill_index     = (r_state == S_UPDATE) ? r_index : '0;
    assign bus.fill_tag       = (r_state == S_UPDATE) ? r_tag : '0;
    assign bus.fill_line      = (r_state == S_UPDATE) ? r_buf : '0;
    assign bus.way_sel_update = (r_state == S_UPDATE);
    assign bus.hit            = (r_state == S_UPDATE) ? w_way_onehot : 2'b00;

    // LRU looks up the incoming miss index while idle so way_sel is ready the same cycle
    assign bus.lru_addr = (r_state == S_IDLE) ? w_miss_index : r_index;
    assign bus.miss_ack = (r_state == S_ACK);
endmodule

// File: tb/tb_cache_refill_ctrl.sv
// tb/tb_cache_refill_ctrl.sv - Randomized directed bench for cache_refill_ctrl against a line-level model
module tb_cache_refill_ctrl;
    localparam int INDEX_W    = 8;
    localparam int LINE_WORDS = 4;
    localparam int TAG_W      = 20;
    localparam int LINE_W     = LINE_WORDS * 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec  = 0;
    int   n_miss = 0;

    always #5 clk = ~clk;

    cache_refill_ctrl_if u_if ();

    cache_refill_ctrl u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.master)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_wr_req"},   128'(u_if.wr_req),         128'(0));
        chk({tag, "_rd_req"},   128'(u_if.rd_req),         128'(0));
        chk({tag, "_wr_addr"},  128'(u_if.wr_addr),        128'(0));
        chk({tag, "_rd_addr"},  128'(u_if.rd_addr),        128'(0));
        chk({tag, "_fill_we"},  128'(u_if.fill_we),        128'(0));
        chk({tag, "_hit"},      128'(u_if.hit),            128'(0));
        chk({tag, "_wsu"},      128'(u_if.way_sel_update), 128'(0));
        chk({tag, "_miss_ack"}, 128'(u_if.miss_ack),       128'(0));
        chk({tag, "_fill_ln"},  128'(u_if.fill_line),      128'(0));
        chk({tag, "_fill_tag"}, 128'(u_if.fill_tag),       128'(0));
    endtask

    task automatic do_miss(input logic [31:0] addr, input bit way, input logic [1:0] vv,
                           input logic [1:0] vd, input int wr_stall, input int rd_stall,
                           input bit gaps, input bit hold, input int abort_at, input bit fixed);
        logic [2*TAG_W-1:0]  vt;
        logic [2*LINE_W-1:0] vl;
        logic [31:0]         beats [LINE_WORDS];
        logic [LINE_W-1:0]   exp_line;
        logic [LINE_W-1:0]   exp_wdata;
        logic [TAG_W-1:0]    seltag;
        logic [31:0]         exp_wr;
        logic [31:0]         exp_rd;
        bit                  exp_wb;
        int                  n;
        int                  gap_budget;

        for (int i = 0; i < 2 * LINE_WORDS; i++) vl[i*32 +: 32] = $urandom;
        vt[TAG_W-1:0]       = TAG_W'($urandom);
        vt[2*TAG_W-1:TAG_W] = TAG_W'($urandom);
        seltag    = way ? vt[2*TAG_W-1:TAG_W] : vt[TAG_W-1:0];
        exp_wdata = way ? vl[2*LINE_W-1:LINE_W] : vl[LINE_W-1:0];
        for (int i = 0; i < LINE_WORDS; i++) begin
            beats[i] = fixed ? 32'hA0 + 32'(i) : $urandom;
            exp_line[i*32 +: 32] = beats[i];
        end
`ifdef CACHE_WRITEBACK_EN
        exp_wb = vv[way] & vd[way];
`else
        exp_wb = 1'b0;
`endif
        exp_wr = (32'(seltag) << 12) | (addr & 32'h0000_0FF0);
        exp_rd = addr & ~32'hF;

        @(negedge clk);
        u_if.miss_req  = 1'b1;
        u_if.miss_addr = addr;
        u_if.way_sel   = way;
        u_if.vic_valid = vv;
        u_if.vic_dirty = vd;
        u_if.vic_tag   = vt;
        u_if.vic_line  = vl;
        u_if.wr_rdy    = 1'b0;
        u_if.rd_rdy    = 1'b0;
        u_if.ret_valid = 1'b0;
        u_if.ret_last  = 1'b0;
        #1;
        chk("idle_lru_addr", 128'(u_if.lru_addr), 128'((addr >> 4) & 32'hFF));
        chk("idle_miss_ack", 128'(u_if.miss_ack), 128'(0));
        @(posedge clk);
        #1;
        // victim inputs change after acceptance and must not matter
        u_if.way_sel   = ~way;
        u_if.vic_valid = ~vv;
        u_if.vic_dirty = ~vd;
        u_if.vic_tag   = ~vt;
        u_if.vic_line  = ~vl;

        if (exp_wb) begin
            for (int c = 0; c <= wr_stall; c++) begin
                @(negedge clk);
                chk("wb_wr_req",  128'(u_if.wr_req),  128'(1));
                chk("wb_wr_addr", 128'(u_if.wr_addr), 128'(exp_wr));
                chk("wb_wr_data", 128'(u_if.wr_data), 128'(exp_wdata));
                chk("wb_rd_req",  128'(u_if.rd_req),  128'(0));
                u_if.wr_rdy = (c == wr_stall);
            end
        end
        for (int c = 0; c <= rd_stall; c++) begin
            @(negedge clk);
            u_if.wr_rdy = 1'b0;
            chk("rd_rd_req",  128'(u_if.rd_req),  128'(1));
            chk("rd_rd_addr", 128'(u_if.rd_addr), 128'(exp_rd));
            chk("rd_wr_req",  128'(u_if.wr_req),  128'(0));
            chk("rd_fill_we", 128'(u_if.fill_we), 128'(0));
            u_if.rd_rdy    = (c == rd_stall);
            u_if.ret_valid = 1'b1;
            u_if.ret_last  = 1'b1;
            u_if.ret_data  = $urandom;
        end

        n = 0;
        gap_budget = 6;
        while (n < LINE_WORDS) begin
            @(negedge clk);
            u_if.rd_rdy = 1'b0;
            chk("refill_rd_req",  128'(u_if.rd_req),         128'(0));
            chk("refill_fill_we", 128'(u_if.fill_we),        128'(0));
            chk("refill_wsu",     128'(u_if.way_sel_update), 128'(0));
            if (abort_at == n) begin
                u_if.ret_valid = 1'b0;
                u_if.ret_last  = 1'b0;
                u_if.miss_req  = 1'b0;
                rst = 1'b1;
                @(negedge clk);
                chk_quiet("abort");
                rst = 1'b0;
                for (int c = 0; c < 3; c++) begin
                    @(negedge clk);
                    chk("abort_fill_we", 128'(u_if.fill_we),        128'(0));
                    chk("abort_wsu",     128'(u_if.way_sel_update), 128'(0));
                    chk("abort_rd_req",  128'(u_if.rd_req),         128'(0));
                end
                return;
            end
            if (gaps && gap_budget > 0 && $urandom_range(1, 0) == 1) begin
                u_if.ret_valid = 1'b0;
                u_if.ret_last  = 1'b1;
                u_if.ret_data  = $urandom;
                gap_budget--;
            end else begin
                u_if.ret_valid = 1'b1;
                u_if.ret_last  = (n == LINE_WORDS - 1);
                u_if.ret_data  = beats[n];
                n++;
            end
        end

        @(negedge clk);
        u_if.ret_valid = 1'b0;
        u_if.ret_last  = 1'b0;
        chk("upd_fill_we",    128'(u_if.fill_we),        128'(way ? 2'b10 : 2'b01));
        chk("upd_hit",        128'(u_if.hit),            128'(way ? 2'b10 : 2'b01));
        chk("upd_wsu",        128'(u_if.way_sel_update), 128'(1));
        chk("upd_fill_index", 128'(u_if.fill_index),     128'((addr >> 4) & 32'hFF));
        chk("upd_fill_tag",   128'(u_if.fill_tag),       128'(addr >> 12));
        chk("upd_fill_line",  128'(u_if.fill_line),      128'(exp_line));
        chk("upd_miss_ack",   128'(u_if.miss_ack),       128'(0));

        @(negedge clk);
        chk("ack_miss_ack", 128'(u_if.miss_ack),       128'(1));
        chk("ack_fill_we",  128'(u_if.fill_we),        128'(0));
        chk("ack_wsu",      128'(u_if.way_sel_update), 128'(0));
        chk("ack_hit",      128'(u_if.hit),            128'(0));
        if (!hold) u_if.miss_req = 1'b0;
    endtask

    initial begin
        u_if.miss_req  = 1'b0;
        u_if.miss_addr = 32'd0;
        u_if.way_sel   = 1'b0;
        u_if.vic_valid = 2'b00;
        u_if.vic_dirty = 2'b00;
        u_if.vic_tag   = '0;
        u_if.vic_line  = '0;
        u_if.wr_rdy    = 1'b0;
        u_if.rd_rdy    = 1'b0;
        u_if.ret_valid = 1'b0;
        u_if.ret_last  = 1'b0;
        u_if.ret_data  = 32'd0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_quiet("reset");
        chk("reset_lru_addr", 128'(u_if.lru_addr), 128'(0));
        rst = 1'b0;

        // clean miss into invalid way1 with fixed beats A0..A3
        do_miss(32'h0000_1230, 1'b1, 2'b01, 2'b10, 0, 0, 1'b0, 1'b0, -1, 1'b1);
        // dirty valid victim in way0
        do_miss(32'hCAFE_0560, 1'b0, 2'b11, 2'b01, 0, 0, 1'b0, 1'b0, -1, 1'b0);
        // write then read backpressure
        do_miss(32'h1357_9BD0, 1'b1, 2'b11, 2'b10, 5, 3, 1'b0, 1'b0, -1, 1'b0);
        // gapped beat return
        do_miss(32'h8000_0FF0, 1'b0, 2'b01, 2'b00, 0, 1, 1'b1, 1'b0, -1, 1'b0);
        // reset after two beats, then a normal miss
        do_miss(32'h2468_ACE0, 1'b1, 2'b11, 2'b11, 1, 0, 1'b0, 1'b0, 2, 1'b0);
        do_miss(32'h2468_ACE0, 1'b1, 2'b10, 2'b00, 0, 0, 1'b0, 1'b0, -1, 1'b0);
        // back-to-back with miss_req held through the acknowledge
        do_miss(32'h0000_4440, 1'b0, 2'b11, 2'b11, 0, 0, 1'b0, 1'b1, -1, 1'b0);
        do_miss(32'hFFFF_F880, 1'b1, 2'b11, 2'b11, 0, 0, 1'b0, 1'b0, -1, 1'b0);

        for (int t = 0; t < 20; t++) begin
            do_miss($urandom, 1'($urandom_range(1, 0)), 2'($urandom), 2'($urandom),
                    int'($urandom_range(2, 0)), int'($urandom_range(2, 0)),
                    1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), -1, 1'b0);
        end

        @(negedge clk);
        u_if.miss_req = 1'b0;
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/cache_refill_ctrl.md
# cache_refill_ctrl

Miss-handling and line-replacement controller for the 2-way set-associative cache. It consumes the victim-way choice from the LRU way selector and writes back a dirty victim line. It then fetches the replacement line from memory, installs it in the victim way, and reports the filled way back to the LRU as a one-hot `hit` with a `way_sel_update` strobe, so the LRU marks it most-recently-used. The block sits between the cache pipeline's miss detector and the memory bus interface.

## Interface
Parameters:
- `INDEX_W`, 8: set index width, equal to the LRU's `RAM_DEPTH_LOG`.
- `LINE_WORDS`, 4: 32-bit words per line, a power of two and at least 2.
- `TAG_W`, 32-INDEX_W-log2(LINE_WORDS)-2: tag width.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `miss_req` in 1: miss pending. Level signal, held until `miss_ack`.
- `miss_addr` in 32: missing byte address, stable while `miss_req` is high.
- `miss_ack` out 1: one-cycle pulse, refill complete.
- `way_sel` in 1: victim way index from the LRU (0 = way0, 1 = way1).
- `vic_valid` in 2: valid bit of each way at the miss index.
- `vic_dirty` in 2: dirty bit of each way at the miss index.
- `vic_tag` in 2*TAG_W: tags of both ways; way1 is in the upper half.
- `vic_line` in 2*LINE_WORDS*32: line data of both ways; way1 is in the upper half.
- `wr_req` out 1: line write-back request.
- `wr_addr` out 32: line-aligned write-back address.
- `wr_data` out LINE_WORDS*32: write-back line; word 0 is in the LSBs.
- `wr_rdy` in 1: memory accepts the write.
- `rd_req` out 1: line read request.
- `rd_addr` out 32: line-aligned read address.
- `rd_rdy` in 1: memory accepts the read.
- `ret_valid` in 1: read data beat valid.
- `ret_last` in 1: final beat of the read.
- `ret_data` in 32: read data beat.
- `fill_we` out 2: one-hot way write enable for the tag and data RAMs.
- `fill_index` out INDEX_W: set index for the fill.
- `fill_tag` out TAG_W: tag written with the fill. The fill writes valid=1 and dirty=0.
- `fill_line` out LINE_WORDS*32: refilled line data.
- `way_sel_update` out 1: LRU update strobe.
- `hit` out 2: one-hot filled way, sent to the LRU.
- `lru_addr` out INDEX_W: index sent to the LRU, driven by the miss index at all times.

## Operation
State machine: IDLE, WB, RD, REFILL, UPDATE, ACK.

- **IDLE**
  - On `miss_req`=1, latch the following:
    - the index, `miss_addr[INDEX_W+log2(LINE_WORDS)+1 : log2(LINE_WORDS)+2]`;
    - the tag, `miss_addr[31 -: TAG_W]`;
    - `way_sel`;
    - the selected way's valid, dirty, tag and line.
  - If the victim is valid and dirty, go to WB; otherwise go to RD.
  - `lru_addr` follows `miss_addr`'s index combinationally in IDLE, so `way_sel` is valid in the same cycle.
- **WB**
  - `wr_req`=1, `wr_addr`={victim tag, index, zero offset}, `wr_data`=victim line.
  - Go to RD on the edge where `wr_req` and `wr_rdy` are both 1.
- **RD**
  - `rd_req`=1, `rd_addr`={miss tag, index, zero offset}.
  - Go to REFILL on the edge where `rd_req` and `rd_rdy` are both 1.
  - The beat counter clears to 0 on entry.
- **REFILL**
  - Each `ret_valid` beat writes `ret_data` into buffer word[counter], then increments the counter modulo LINE_WORDS (wraps).
  - A beat with `ret_valid` and `ret_last` both 1 is stored and moves to UPDATE; `ret_last` is authoritative.
  - `ret_valid`=0 cycles hold state.
- **UPDATE** (exactly one cycle):
  - `fill_we`=one-hot(latched way);
  - `fill_index`, `fill_tag` and `fill_line` driven from the latched and buffered values;
  - `way_sel_update`=1 and `hit`=one-hot(latched way).
  - Go to ACK.
- **ACK**: `miss_ack`=1 for one cycle, then go to IDLE.
  - `miss_req` still high in the next IDLE cycle is treated as a new miss.
- `fill_we`, `way_sel_update` and `hit` are 0 outside UPDATE.
- `wr_req` is 0 outside WB; `rd_req` is 0 outside RD.

## Timing
- Reset:
  - state becomes IDLE; every output register is 0, including `miss_ack`, `wr_req`, `rd_req`, `fill_we`, `hit`, `way_sel_update` and the data and address outputs;
  - the counter and buffer clear.
  - Reset mid-operation (any state) abandons the transaction. Requests drop in the cycle after the reset edge, and no fill or LRU update occurs.
- Minimum clean-miss latency:
  - `miss_req` sampled at edge 0;
  - `rd_req` high from edge 0 to edge 1, with `rd_rdy`=1;
  - LINE_WORDS back-to-back beats;
  - `way_sel_update` in the cycle after the last beat;
  - `miss_ack` one cycle later.
- `ret_valid` arriving in states other than REFILL is ignored.
- Victim metadata and `way_sel` are sampled only at the IDLE→WB/RD edge. Later changes have no effect.

## Configuration
- `CACHE_WRITEBACK_EN` defined:
  - WB state present; dirty victims are written back before the refill.
- Undefined (write-through cache):
  - WB state removed; `vic_dirty` is ignored;
  - `wr_req` is tied 0, and `wr_addr` and `wr_data` are tied 0;
  - IDLE always goes to RD.

## Test plan
- **Clean miss.** `way_sel`=1, way1 invalid, miss_addr=0x0000_1230, `rd_rdy`=1, 4 beats 0xA0..0xA3.
  - `rd_addr`=0x0000_1230 & ~0xF.
  - `fill_we`=2'b10 with `fill_line`={A3,A2,A1,A0}.
  - `hit`=2'b10 and `way_sel_update`=1 for 1 cycle; `miss_ack` the next cycle; `wr_req` never asserted.
- **Dirty victim** (`CACHE_WRITEBACK_EN` defined). `way_sel`=0, way0 valid and dirty with tag T.
  - `wr_req` with `wr_addr`={T,index,0} precedes `rd_req`.
  - `fill_we`=2'b01, `hit`=2'b01.
- **Backpressure.** `wr_rdy` low 5 cycles, then `rd_rdy` low 3 cycles.
  - `wr_req` and `rd_req` stay high and stable, each transfers exactly once, and the fill data is correct.
- **Gapped return.** `ret_valid` gaps between beats.
  - Buffer order is preserved; UPDATE only after `ret_last`.
- **Reset mid-REFILL** after 2 beats.
  - All outputs are 0 next cycle; no `fill_we` or `way_sel_update`.
  - A subsequent miss completes normally.
- **Back-to-back misses.** `miss_req` held high through `miss_ack`.
  - A second transaction starts in the IDLE cycle after ACK, with `lru_addr` and `way_sel` resampled.
